// File: rtl/dll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dll_pkg
// Purpose  : Shared definitions for the data-link-layer TX arbiter slice.
//            - DATA_W / DLLP_W : default widths of the framed TLP word and of
//                                a framed DLLP
//            - src_e           : identifies which requester won a grant
//            - outreg_state_e  : state encoding of the output holding register
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dll_pkg;

  localparam int unsigned DATA_W = 1196;  // seq + TLP + LCRC
  localparam int unsigned DLLP_W = 48;    // framed DLLP

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ACK  = 2'd1,
    SRC_FC   = 2'd2,
    SRC_TLP  = 2'd3
  } src_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,  // register empty
    ST_HOLD = 1'b1   // register valid, waiting on tx_ready_i
  } outreg_state_e;

endpackage
`default_nettype wire

// File: rtl/dll_tx_outreg.sv
`default_nettype none
// ============================================================================
// Module   : dll_tx_outreg
// Purpose  : Single-entry output holding register for the TX arbiter. A word
//            loaded in one cycle is presented on the following cycle and is
//            held stable until the link side accepts it.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            load_i            - load a new word this cycle
//            load_data_i       - word to load
//            load_is_dllp_i    - loaded word is a DLLP
//            tx_ready_i        - link side accepts the presented word
//            can_load_o        - register empty or being drained this cycle
//            tx_valid_o        - presented word valid
//            tx_data_o         - presented word
//            tx_is_dllp_o      - presented word is a DLLP
// Revision : 1.0 - initial release
// ============================================================================
module dll_tx_outreg #(
  parameter int unsigned DATA_W = dll_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_is_dllp_i,
  input  logic              tx_ready_i,
  output logic              can_load_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_is_dllp_o
);

  import dll_pkg::*;

  outreg_state_e     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              is_dllp_q, is_dllp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      is_dllp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      is_dllp_q <= is_dllp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    is_dllp_d = is_dllp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Drained with nothing behind it: go empty. A back-to-back load keeps
        // the register in HOLD with the new word.
        if (tx_ready_i && !load_i) begin
          state_d   = ST_IDLE;
          is_dllp_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_i) begin
      data_d    = load_data_i;
      is_dllp_d = load_is_dllp_i;
    end
  end

  assign can_load_o   = (state_q == ST_IDLE) || tx_ready_i;
  assign tx_valid_o   = (state_q == ST_HOLD);
  assign tx_data_o    = data_q;
  assign tx_is_dllp_o = is_dllp_q && (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: rtl/dll_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dll_tx_arbiter
// Purpose  : Arbitrates Ack/Nak DLLPs, UpdateFC DLLPs and framed TLPs onto the
//            single link-side TX stream. Fixed priority Ack/Nak > UpdateFC >
//            TLP, with a starvation counter that forces a waiting TLP through
//            after STARVE_MAX consecutive DLLP grants.
//            Optional feature (macro DLL_TX_FC_TIMER_EN): an UpdateFC refresh
//            timer that pulses fc_refresh_o every FC_TIMER_CYCLES cycles
//            without an UpdateFC grant and then lifts UpdateFC above Ack/Nak
//            until the next UpdateFC grant.
// Ports    : clk, rst                              - clock, sync active-high reset
//            ack_valid_i/ack_dllp_i/ack_ready_o    - Ack/Nak DLLP requester
//            fc_valid_i/fc_dllp_i/fc_ready_o       - UpdateFC DLLP requester
//            tlp_valid_i/tlp_data_i/tlp_ready_o    - framed TLP requester
//            tx_valid_o/tx_data_o/tx_ready_i       - link-side output
//            tx_is_dllp_o                          - presented word is a DLLP
//            fc_refresh_o                          - one-cycle UpdateFC refresh
// Revision : 1.0 - initial release
// ============================================================================
module dll_tx_arbiter #(
  parameter int unsigned DATA_W          = dll_pkg::DATA_W,
  parameter int unsigned DLLP_W          = dll_pkg::DLLP_W,
  parameter int unsigned STARVE_MAX      = 4,
  parameter int unsigned FC_TIMER_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ack_valid_i,
  input  logic [DLLP_W-1:0] ack_dllp_i,
  output logic              ack_ready_o,
  input  logic              fc_valid_i,
  input  logic [DLLP_W-1:0] fc_dllp_i,
  output logic              fc_ready_o,
  input  logic              tlp_valid_i,
  input  logic [DATA_W-1:0] tlp_data_i,
  output logic              tlp_ready_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  output logic              tx_is_dllp_o,
  output logic              fc_refresh_o
);

  import dll_pkg::*;

  localparam int unsigned         STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  src_e                grant;
  logic                can_load;
  logic                load;
  logic                load_is_dllp;
  logic [DATA_W-1:0]   load_data;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                fc_urgent;

  // --------------------------------------------------------------------------
  // Grant selection. Nothing is granted while in reset or while the output
  // register is full and not draining.
  // --------------------------------------------------------------------------
  always_comb begin
    grant = SRC_NONE;
    if (!rst && can_load) begin
      if (tlp_valid_i && (starve_q == STARVE_LIM)) grant = SRC_TLP;
      else if (fc_urgent && fc_valid_i)            grant = SRC_FC;
      else if (ack_valid_i)                        grant = SRC_ACK;
      else if (fc_valid_i)                         grant = SRC_FC;
      else if (tlp_valid_i)                        grant = SRC_TLP;
    end
  end

  assign ack_ready_o = (grant == SRC_ACK);
  assign fc_ready_o  = (grant == SRC_FC);
  assign tlp_ready_o = (grant == SRC_TLP);
  assign load        = (grant != SRC_NONE);

  // DLLPs ride in the low bits of the TX word with the upper bits zeroed.
  always_comb begin
    load_data    = tlp_data_i;
    load_is_dllp = 1'b0;
    if (grant == SRC_ACK) begin
      load_data    = {{(DATA_W-DLLP_W){1'b0}}, ack_dllp_i};
      load_is_dllp = 1'b1;
    end else if (grant == SRC_FC) begin
      load_data    = {{(DATA_W-DLLP_W){1'b0}}, fc_dllp_i};
      load_is_dllp = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: consecutive DLLP grants while a TLP is waiting.
  // Saturates at STARVE_LIM; at the limit the TLP wins the next grant anyway.
  // --------------------------------------------------------------------------
  always_comb begin
    starve_d = starve_q;
    if (!tlp_valid_i || (grant == SRC_TLP)) begin
      starve_d = '0;
    end else if (((grant == SRC_ACK) || (grant == SRC_FC)) && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  // --------------------------------------------------------------------------
  // UpdateFC refresh timer
  // --------------------------------------------------------------------------
`ifdef DLL_TX_FC_TIMER_EN
  localparam int unsigned         FC_TMR_W   = $clog2(FC_TIMER_CYCLES + 1);
  localparam logic [FC_TMR_W-1:0] FC_TMR_END = FC_TMR_W'(FC_TIMER_CYCLES - 1);

  logic [FC_TMR_W-1:0] fc_tmr_q, fc_tmr_d;
  logic                fc_refresh_q, fc_refresh_d;
  logic                fc_urgent_q, fc_urgent_d;

  // An UpdateFC grant restarts the interval and clears any pending urgency;
  // otherwise the timer wraps every FC_TIMER_CYCLES cycles with a pulse.
  always_comb begin
    fc_tmr_d     = fc_tmr_q + FC_TMR_W'(1);
    fc_refresh_d = 1'b0;
    fc_urgent_d  = fc_urgent_q;
    if (grant == SRC_FC) begin
      fc_tmr_d    = '0;
      fc_urgent_d = 1'b0;
    end else if (fc_tmr_q == FC_TMR_END) begin
      fc_tmr_d     = '0;
      fc_refresh_d = 1'b1;
      fc_urgent_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_tmr_q     <= '0;
      fc_refresh_q <= 1'b0;
      fc_urgent_q  <= 1'b0;
    end else begin
      fc_tmr_q     <= fc_tmr_d;
      fc_refresh_q <= fc_refresh_d;
      fc_urgent_q  <= fc_urgent_d;
    end
  end

  assign fc_urgent    = fc_urgent_q;
  assign fc_refresh_o = fc_refresh_q;
`else
  assign fc_urgent    = 1'b0;
  assign fc_refresh_o = 1'b0;

  // The refresh interval has no meaning without the timer; a zero interval
  // would be a configuration error in the timer build, so nothing is built.
  if (FC_TIMER_CYCLES == 0) begin : g_fc_timer_cfg_unused
  end
`endif

  // --------------------------------------------------------------------------
  // Output holding register
  // --------------------------------------------------------------------------
  dll_tx_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load),
    .load_data_i    (load_data),
    .load_is_dllp_i (load_is_dllp),
    .tx_ready_i     (tx_ready_i),
    .can_load_o     (can_load),
    .tx_valid_o     (tx_valid_o),
    .tx_data_o      (tx_data_o),
    .tx_is_dllp_o   (tx_is_dllp_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dll_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dll_tx_arbiter
// Purpose  : Directed self-checking bench for dll_tx_arbiter. The refresh
//            timer section follows macro DLL_TX_FC_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dll_tx_arbiter;

  localparam int DW = 1196;
  localparam int LW = 48;
`ifdef DLL_TX_FC_TIMER_EN
  localparam int FCC = 16;
`else
  localparam int FCC = 1024;
`endif

  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};
  localparam logic [DW-1:0] P5   = {299{4'h5}};
  localparam logic [DW-1:0] PA   = {299{4'hA}};
  localparam logic [LW-1:0] ACK1 = 48'hBEEF_8A_00_55_11;
  localparam logic [LW-1:0] ACK2 = 48'h0000_1111_2222;
  localparam logic [LW-1:0] FC1  = 48'h1234_5678_9ABC;

  logic          clk = 1'b0;
  logic          rst;
  logic          ack_valid_i, ack_ready_o;
  logic [LW-1:0] ack_dllp_i;
  logic          fc_valid_i, fc_ready_o;
  logic [LW-1:0] fc_dllp_i;
  logic          tlp_valid_i, tlp_ready_o;
  logic [DW-1:0] tlp_data_i;
  logic          tx_valid_o, tx_ready_i, tx_is_dllp_o, fc_refresh_o;
  logic [DW-1:0] tx_data_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dll_tx_arbiter #(
    .DATA_W          (DW),
    .DLLP_W          (LW),
    .STARVE_MAX      (4),
    .FC_TIMER_CYCLES (FCC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ack_valid_i  (ack_valid_i),
    .ack_dllp_i   (ack_dllp_i),
    .ack_ready_o  (ack_ready_o),
    .fc_valid_i   (fc_valid_i),
    .fc_dllp_i    (fc_dllp_i),
    .fc_ready_o   (fc_ready_o),
    .tlp_valid_i  (tlp_valid_i),
    .tlp_data_i   (tlp_data_i),
    .tlp_ready_o  (tlp_ready_o),
    .tx_valid_o   (tx_valid_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready_i),
    .tx_is_dllp_o (tx_is_dllp_o),
    .fc_refresh_o (fc_refresh_o)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h..%h expected=%h..%h (top/bottom 64 bits)",
             tag, obs[DW-1 -: 64], obs[63:0], exp[DW-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dext(input logic [LW-1:0] d);
    return {{(DW-LW){1'b0}}, d};
  endfunction

  initial begin
    rst = 1'b1;
    ack_valid_i = 1'b0; ack_dllp_i = '0;
    fc_valid_i  = 1'b0; fc_dllp_i  = '0;
    tlp_valid_i = 1'b0; tlp_data_i = '0;
    tx_ready_i  = 1'b0;
    tick;
    tick;

    // ---- reset state, readies held low while in reset
    ack_valid_i = 1'b1; fc_valid_i = 1'b1; tlp_valid_i = 1'b1;
    #1;
    chk("rst_ack_ready", ack_ready_o, 1'b0);
    chk("rst_fc_ready", fc_ready_o, 1'b0);
    chk("rst_tlp_ready", tlp_ready_o, 1'b0);
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_is_dllp", tx_is_dllp_o, 1'b0);
    chk("rst_fc_refresh", fc_refresh_o, 1'b0);
    chk_data("rst_tx_data", tx_data_o, '0);
    ack_valid_i = 1'b0; fc_valid_i = 1'b0; tlp_valid_i = 1'b0;
    tick;
    rst = 1'b0;
    tx_ready_i = 1'b1;

    // ---- refresh timer
`ifdef DLL_TX_FC_TIMER_EN
    for (int k = 1; k <= FCC; k++) begin
      tick;
      chk($sformatf("fc_refresh_cyc%0d", k), fc_refresh_o, (k == FCC));
    end
    ack_valid_i = 1'b1; ack_dllp_i = ACK1;
    fc_valid_i  = 1'b1; fc_dllp_i  = FC1;
    #1;
    chk("urgent_fc_ready", fc_ready_o, 1'b1);
    chk("urgent_ack_ready", ack_ready_o, 1'b0);
    tick;
    chk_data("urgent_fc_data", tx_data_o, dext(FC1));
    chk("urgent_refresh_one_cycle", fc_refresh_o, 1'b0);
    chk("after_fc_ack_ready", ack_ready_o, 1'b1);
    ack_valid_i = 1'b0; fc_valid_i = 1'b0;
    tick;
`else
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk($sformatf("fc_refresh_low_cyc%0d", k), fc_refresh_o, 1'b0);
    end
`endif
    rst = 1'b1;
    tick;
    rst = 1'b0;

    // ---- ack and fc in the same cycle: ack first, fc next
    ack_valid_i = 1'b1; ack_dllp_i = ACK1;
    fc_valid_i  = 1'b1; fc_dllp_i  = FC1;
    tx_ready_i  = 1'b1;
    #1;
    chk("t1_ack_ready", ack_ready_o, 1'b1);
    chk("t1_fc_ready_low", fc_ready_o, 1'b0);
    chk("t1_tlp_ready_low", tlp_ready_o, 1'b0);
    tick;
    ack_valid_i = 1'b0;
    #1;
    chk("t1_ack_valid", tx_valid_o, 1'b1);
    chk("t1_ack_is_dllp", tx_is_dllp_o, 1'b1);
    chk_data("t1_ack_data", tx_data_o, dext(ACK1));
    chk("t1_fc_ready", fc_ready_o, 1'b1);
    tick;
    fc_valid_i = 1'b0;
    #1;
    chk("t1_fc_is_dllp", tx_is_dllp_o, 1'b1);
    chk_data("t1_fc_data", tx_data_o, dext(FC1));
    tick;
    chk("t1_empty", tx_valid_o, 1'b0);

    // ---- starvation: four acks then the TLP, repeating
    tlp_valid_i = 1'b1; tlp_data_i = ALL1;
    ack_valid_i = 1'b1; ack_dllp_i = ACK2;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("t2_is_dllp_%0d", k), tx_is_dllp_o, (k % 5 != 4));
      chk_data($sformatf("t2_data_%0d", k), tx_data_o, (k % 5 == 4) ? ALL1 : dext(ACK2));
    end
    ack_valid_i = 1'b0; tlp_valid_i = 1'b0;
    tick;
    chk("t2_empty", tx_valid_o, 1'b0);

    // ---- backpressure: TLP held 5 cycles, drains on the 6th
    tx_ready_i = 1'b0;
    tlp_valid_i = 1'b1; tlp_data_i = P5;
    #1;
    chk("t3_tlp_ready", tlp_ready_o, 1'b1);
    tick;
    tlp_data_i = PA; ack_valid_i = 1'b1; fc_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_valid_%0d", i), tx_valid_o, 1'b1);
      chk_data($sformatf("t3_data_%0d", i), tx_data_o, P5);
      chk($sformatf("t3_ack_ready_%0d", i), ack_ready_o, 1'b0);
      chk($sformatf("t3_fc_ready_%0d", i), fc_ready_o, 1'b0);
      chk($sformatf("t3_tlp_ready_%0d", i), tlp_ready_o, 1'b0);
      tick;
    end
    ack_valid_i = 1'b0; fc_valid_i = 1'b0; tlp_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    #1;
    chk("t3_still_valid", tx_valid_o, 1'b1);
    chk_data("t3_still_data", tx_data_o, P5);
    tick;
    chk("t3_drained", tx_valid_o, 1'b0);

    // ---- reset while holding a TLP
    tx_ready_i = 1'b0;
    tlp_valid_i = 1'b1; tlp_data_i = PA;
    tick;
    tlp_valid_i = 1'b0;
    #1;
    chk("t4_hold_valid", tx_valid_o, 1'b1);
    chk_data("t4_hold_data", tx_data_o, PA);
    rst = 1'b1; tlp_valid_i = 1'b1; ack_valid_i = 1'b1;
    #1;
    chk("t4_rst_tlp_ready", tlp_ready_o, 1'b0);
    chk("t4_rst_ack_ready", ack_ready_o, 1'b0);
    tick;
    chk("t4_valid_cleared", tx_valid_o, 1'b0);
    chk("t4_is_dllp_cleared", tx_is_dllp_o, 1'b0);
    chk_data("t4_data_cleared", tx_data_o, '0);
    rst = 1'b0; tlp_valid_i = 1'b0; ack_valid_i = 1'b0; tx_ready_i = 1'b1;
    tick;
    chk("t4_no_output_1", tx_valid_o, 1'b0);
    tick;
    chk("t4_no_output_2", tx_valid_o, 1'b0);

    // ---- UpdateFC ahead of TLP
    fc_valid_i = 1'b1; fc_dllp_i = FC1;
    tlp_valid_i = 1'b1; tlp_data_i = PA;
    #1;
    chk("t5_fc_ready", fc_ready_o, 1'b1);
    chk("t5_tlp_ready_low", tlp_ready_o, 1'b0);
    tick;
    fc_valid_i = 1'b0;
    #1;
    chk_data("t5_fc_data", tx_data_o, dext(FC1));
    chk("t5_tlp_ready", tlp_ready_o, 1'b1);
    tick;
    tlp_valid_i = 1'b0;
    chk("t5_tlp_is_dllp", tx_is_dllp_o, 1'b0);
    chk_data("t5_tlp_data", tx_data_o, PA);
    tick;
    chk("t5_empty", tx_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dll_tx_arbiter.md
DLL_TX_ARBITER -- requirements
Module: dll_tx_arbiter

Interface
- REQ-001 SHALL have parameter DATA_W, default 1196, meaning width of the framed TX word (seq + TLP + LCRC).
- REQ-002 SHALL have parameter DLLP_W, default 48, meaning width of a framed DLLP.
- REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning maximum consecutive DLLP grants while a TLP waits.
- REQ-004 SHALL have parameter FC_TIMER_CYCLES, default 1024, meaning UpdateFC refresh interval (used only under REQ-030).
- REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
- REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
- REQ-007 SHALL have ports ack_valid_i  input  1, ack_dllp_i  input  DLLP_W, ack_ready_o  output  1  (Ack/Nak DLLP requester).
- REQ-008 SHALL have ports fc_valid_i  input  1, fc_dllp_i  input  DLLP_W, fc_ready_o  output  1  (UpdateFC DLLP requester).
- REQ-009 SHALL have ports tlp_valid_i  input  1, tlp_data_i  input  DATA_W, tlp_ready_o  output  1  (framed TLP requester).
- REQ-010 SHALL have ports tx_valid_o  output  1, tx_data_o  output  DATA_W, tx_ready_i  input  1  (link-side output).
- REQ-011 SHALL have ports tx_is_dllp_o  output  1  (current output is a DLLP), fc_refresh_o  output  1  (one-cycle refresh request to the UpdateFC generator).

Function
- REQ-012 SHALL accept a requester only in a cycle where its valid and its ready are both high (transfer).
- REQ-013 SHALL assert at most one of ack_ready_o, fc_ready_o, tlp_ready_o in any cycle.
- REQ-014 SHALL assert a requester ready only when the output register is empty or is being drained in that cycle (tx_valid_o & tx_ready_i).
- REQ-015 SHALL use fixed priority Ack/Nak > UpdateFC > TLP, overridden by REQ-017.
- REQ-016 SHALL count consecutive DLLP grants in a starve counter while tlp_valid_i is high; counter clears on a TLP grant or when tlp_valid_i is low.
- REQ-017 SHALL grant the TLP ahead of any DLLP when the starve counter equals STARVE_MAX and tlp_valid_i is high.
- REQ-018 SHALL present an accepted request on tx_data_o/tx_valid_o in the next cycle (latency 1).
- REQ-019 SHALL place a DLLP in tx_data_o[DLLP_W-1:0] with all upper bits zero and set tx_is_dllp_o; TLPs pass unmodified with tx_is_dllp_o low.
- REQ-020 SHALL hold tx_data_o, tx_valid_o, tx_is_dllp_o stable while tx_valid_o is high and tx_ready_i is low.
- REQ-021 SHALL implement FSM IDLE (register empty), HOLD (valid, waiting on tx_ready_i); IDLE->HOLD on any grant; HOLD->IDLE on drain with no new grant; HOLD->HOLD on drain with back-to-back grant.
- REQ-022 SHALL sustain one transfer per cycle when tx_ready_i stays high and requests are continuous.
- REQ-023 SHALL, with all three requesters valid simultaneously and starve counter below STARVE_MAX, grant Ack/Nak.
- REQ-024 SHALL saturate the starve counter at STARVE_MAX (no wrap).
- REQ-025 SHALL drive fc_refresh_o low when REQ-030 is compiled out.

Reset
- REQ-026 SHALL, while rst is high at a clock edge, clear tx_valid_o, tx_is_dllp_o, fc_refresh_o, all ready outputs, starve counter and FC timer, and enter IDLE.
- REQ-027 SHALL clear tx_data_o to zero on reset.
- REQ-028 SHALL discard an output held in HOLD when reset arrives mid-transfer; no transfer is reported for it.
- REQ-029 SHALL deassert all ready outputs during any cycle in which rst is high.

Configuration
- REQ-030 SHALL, with macro DLL_TX_FC_TIMER_EN defined, run a FC timer counting cycles since the last UpdateFC grant; at FC_TIMER_CYCLES it pulses fc_refresh_o for one cycle, restarts, and raises UpdateFC above Ack/Nak until the next UpdateFC grant.
- REQ-031 SHALL, without DLL_TX_FC_TIMER_EN, contain no timer logic and use priority per REQ-015 only.

Structure
- REQ-032 SHALL take DATA_W, DLLP_W and a grant-source enum (SRC_NONE, SRC_ACK, SRC_FC, SRC_TLP) from shared package dll_pkg.
- REQ-033 SHALL implement the output holding register (REQ-018..020) as sub-module dll_tx_outreg; grant logic stays in the top.

Verification
- REQ-034 SHALL cover: ack and fc valid same cycle, ack_dllp_i=48'hBEEF_8A_00_55_11, tx_ready_i=1 -> ack on tx_data_o next cycle with tx_is_dllp_o=1, upper bits zero; fc one cycle later.
- REQ-035 SHALL cover: tlp_valid_i held with tlp_data_i all-ones, ack_valid_i held continuously -> exactly 4 ack outputs then the TLP, repeating.
- REQ-036 SHALL cover: TLP accepted with tx_ready_i=0 for 5 cycles -> tx_data_o stable, all readies low 5 cycles, drains on cycle 6.
- REQ-037 SHALL cover: rst=1 while in HOLD with TLP pending -> next cycle tx_valid_o=0, tx_data_o=0, no output of that TLP.
- REQ-038 SHALL cover: DLL_TX_FC_TIMER_EN defined, FC_TIMER_CYCLES=16, no fc grant -> fc_refresh_o pulses at cycle 16; fc then wins over simultaneous ack.
